// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command path: sync marker, opcodes, error causes
// and decoder states. The response encoder uses the same package.
package uart_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    localparam logic [7:0] OPC_READ   = 8'h01;
    localparam logic [7:0] OPC_WRITE  = 8'h02;
    localparam logic [7:0] OPC_ERASE  = 8'h03;
    localparam logic [7:0] OPC_STATUS = 8'h04;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_CHECKSUM = 2'd1,
        ERR_OPCODE   = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } err_code_t;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_OPC,
        ST_ADDR,
        ST_LEN,
        ST_CHECK,
        ST_HOLD
    } dec_state_t;

    function automatic logic is_known_opcode(input logic [7:0] opc);
        return (opc == OPC_READ) || (opc == OPC_WRITE) ||
               (opc == OPC_ERASE) || (opc == OPC_STATUS);
    endfunction

endpackage

// File: rtl/uart_timeout.sv
// Inter-byte timeout: counts idle cycles while enabled, saturates at the limit and
// flags expiry for as long as the limit is held.
module uart_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (!enable || clear) begin
            count_next = '0;
        end else if (count_reg != LIMIT) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    // Expiry wins over a byte arriving in the same cycle; the decoder drops it.
    assign expired = enable && (count_reg == LIMIT);

endmodule

// File: rtl/uart_cmd_decoder.sv
// Decodes 8-byte SYNC/OPC/A0..A2/L0..L1/CHK frames from a UART byte stream into
// a held command with a valid/ready handshake, reporting rejected frames.
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rxData,
    input  logic        rxValid,
    output logic        cmdValid,
    input  logic        cmdReady,
    output logic [7:0]  cmdOpcode,
    output logic [23:0] cmdAddr,
    output logic [15:0] cmdLength,
    output logic        frameError,
    output logic [1:0]  errCode,
    output logic        overrun
);

    dec_state_t  state_reg, state_next;
    logic [1:0]  byte_idx_reg, byte_idx_next;
    logic [7:0]  xor_reg, xor_next;
    logic [7:0]  opc_reg, opc_next;
    logic [23:0] addr_reg, addr_next;
    logic [15:0] len_reg, len_next;
    logic [7:0]  cmd_opcode_reg, cmd_opcode_next;
    logic [23:0] cmd_addr_reg, cmd_addr_next;
    logic [15:0] cmd_length_reg, cmd_length_next;
    err_code_t   err_code_reg, err_code_next;
    logic        frame_error_reg, frame_error_next;
    logic        overrun_reg, overrun_next;

    logic tmo_enable;
    logic tmo_expired;

    assign tmo_enable = (state_reg == ST_OPC) || (state_reg == ST_ADDR) ||
                        (state_reg == ST_LEN) || (state_reg == ST_CHECK);

    uart_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (rxValid),
        .enable (tmo_enable),
        .expired(tmo_expired)
    );

    always_comb begin
        state_next       = state_reg;
        byte_idx_next    = byte_idx_reg;
        xor_next         = xor_reg;
        opc_next         = opc_reg;
        addr_next        = addr_reg;
        len_next         = len_reg;
        cmd_opcode_next  = cmd_opcode_reg;
        cmd_addr_next    = cmd_addr_reg;
        cmd_length_next  = cmd_length_reg;
        err_code_next    = err_code_reg;
        frame_error_next = 1'b0;
        overrun_next     = 1'b0;

        if (tmo_expired) begin
            state_next       = ST_HUNT;
            frame_error_next = 1'b1;
            err_code_next    = ERR_TIMEOUT;
        end else begin
            case (state_reg)
                ST_HUNT: begin
                    if (rxValid && (rxData == SYNC_BYTE)) begin
                        state_next    = ST_OPC;
                        xor_next      = '0;
                        byte_idx_next = '0;
                    end
                end
                ST_OPC: begin
                    if (rxValid) begin
                        opc_next      = rxData;
                        xor_next      = xor_reg ^ rxData;
                        byte_idx_next = '0;
                        state_next    = ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    // Little-endian: shifting in from the top leaves A0 in bits [7:0].
                    if (rxValid) begin
                        addr_next = {rxData, addr_reg[23:8]};
                        xor_next  = xor_reg ^ rxData;
                        if (byte_idx_reg == 2'd2) begin
                            byte_idx_next = '0;
                            state_next    = ST_LEN;
                        end else begin
                            byte_idx_next = byte_idx_reg + 2'd1;
                        end
                    end
                end
                ST_LEN: begin
                    if (rxValid) begin
                        len_next = {rxData, len_reg[15:8]};
                        xor_next = xor_reg ^ rxData;
                        if (byte_idx_reg == 2'd1) begin
                            byte_idx_next = '0;
                            state_next    = ST_CHECK;
                        end else begin
                            byte_idx_next = byte_idx_reg + 2'd1;
                        end
                    end
                end
                ST_CHECK: begin
                    if (rxValid) begin
                        if (rxData != xor_reg) begin
                            state_next       = ST_HUNT;
                            frame_error_next = 1'b1;
                            err_code_next    = ERR_CHECKSUM;
                        end else if (!is_known_opcode(opc_reg)) begin
                            state_next       = ST_HUNT;
                            frame_error_next = 1'b1;
                            err_code_next    = ERR_OPCODE;
                        end else begin
                            state_next      = ST_HOLD;
                            cmd_opcode_next = opc_reg;
                            cmd_addr_next   = addr_reg;
                            cmd_length_next = len_reg;
                        end
                    end
                end
                ST_HOLD: begin
                    // A byte landing on the handshake cycle is hunted, not dropped.
                    if (cmdReady) begin
                        state_next = ST_HUNT;
                        if (rxValid && (rxData == SYNC_BYTE)) begin
                            state_next    = ST_OPC;
                            xor_next      = '0;
                            byte_idx_next = '0;
                        end
                    end else if (rxValid) begin
                        overrun_next = 1'b1;
                    end
                end
                default: begin
                    state_next = ST_HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_HUNT;
            byte_idx_reg    <= '0;
            xor_reg         <= '0;
            opc_reg         <= '0;
            addr_reg        <= '0;
            len_reg         <= '0;
            cmd_opcode_reg  <= '0;
            cmd_addr_reg    <= '0;
            cmd_length_reg  <= '0;
            err_code_reg    <= ERR_NONE;
            frame_error_reg <= 1'b0;
            overrun_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            byte_idx_reg    <= byte_idx_next;
            xor_reg         <= xor_next;
            opc_reg         <= opc_next;
            addr_reg        <= addr_next;
            len_reg         <= len_next;
            cmd_opcode_reg  <= cmd_opcode_next;
            cmd_addr_reg    <= cmd_addr_next;
            cmd_length_reg  <= cmd_length_next;
            err_code_reg    <= err_code_next;
            frame_error_reg <= frame_error_next;
            overrun_reg     <= overrun_next;
        end
    end

    assign cmdValid   = (state_reg == ST_HOLD);
    assign cmdOpcode  = cmd_opcode_reg;
    assign cmdAddr    = cmd_addr_reg;
    assign cmdLength  = cmd_length_reg;
    assign frameError = frame_error_reg;
    assign errCode    = err_code_reg;
    assign overrun    = overrun_reg;

endmodule
